// File: rtl/mig_tt_sweeper_pkg.sv
// mig_tb_pkg: shared sweep state encoding, latency bound and truth-table width helper
package mig_tb_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;
  localparam int MAX_LATENCY = 7;
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/mig_tt_sweeper_if.sv
// mig_tt_sweeper_if: stimulus/result bundle between a sweeper and its netlist-side harness
interface mig_tt_sweeper_if #(parameter int NUM_PI = 5);
  localparam int TT_W = mig_tb_pkg::tt_width(NUM_PI);
  logic start;
  logic [TT_W-1:0] expected_tt;
  logic [NUM_PI-1:0] pi;
  logic po;
  logic busy;
  logic done;
  logic pass;
  logic [TT_W-1:0] captured_tt;
  logic [NUM_PI:0] mismatch_cnt;
  logic [NUM_PI-1:0] first_bad;
  modport master (output start, expected_tt, po, input pi, busy, done, pass, captured_tt, mismatch_cnt, first_bad);
  modport slave (input start, expected_tt, po, output pi, busy, done, pass, captured_tt, mismatch_cnt, first_bad);
endinterface

// File: rtl/mig_sample_delay.sv
// mig_sample_delay: LATENCY-deep valid+index shift register matching the netlist pipeline
module mig_sample_delay #(
  parameter int LATENCY = 0,
  parameter int W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_v,
  input  logic [W-1:0] in_idx,
  output logic out_v,
  output logic [W-1:0] out_idx
);
  if (LATENCY == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign out_v = in_v;
    assign out_idx = in_idx;
  end else begin : g_sr
    logic [LATENCY-1:0] v;
    logic [W-1:0] ix [LATENCY];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v <= '0;
        for (int i = 0; i < LATENCY; i++) ix[i] <= '0;
      end else begin
        v[0] <= in_v;
        ix[0] <= in_idx;
        for (int i = 1; i < LATENCY; i++) begin
          v[i] <= v[i-1];
          ix[i] <= ix[i-1];
        end
      end
    assign out_v = v[LATENCY-1];
    assign out_idx = ix[LATENCY-1];
  end
endmodule

// File: rtl/mig_tt_sweeper.sv
// mig_tt_sweeper: drives all input vectors into a netlist and checks po0 against a golden truth table
module mig_tt_sweeper import mig_tb_pkg::*; #(
  parameter int NUM_PI = 5,
  parameter int LATENCY = 0
) (
  input logic clk,
  input logic rst_n,
  mig_tt_sweeper_if.slave bus
);
  localparam int TT_W = tt_width(NUM_PI);
  state_t state;
  logic [NUM_PI:0] drv_idx;
  logic [TT_W-1:0] exp_q;
  logic [2:0] dcnt;
  logic drv_v;
  logic tap_v;
  logic [NUM_PI-1:0] tap_idx;
  assign drv_v = state == DRIVE;
  // pi itself is the first delay entry, so the tap lines up with po after LATENCY stages
  mig_sample_delay #(.LATENCY(LATENCY), .W(NUM_PI)) u_dly (
    .clk(clk),
    .rst_n(rst_n),
    .in_v(drv_v),
    .in_idx(bus.pi),
    .out_v(tap_v),
    .out_idx(tap_idx)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      drv_idx <= '0;
      exp_q <= '0;
      dcnt <= '0;
      bus.pi <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
      bus.captured_tt <= '0;
      bus.mismatch_cnt <= '0;
      bus.first_bad <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state <= DRIVE;
          exp_q <= bus.expected_tt;
          bus.captured_tt <= '0;
          bus.mismatch_cnt <= '0;
          bus.first_bad <= '0;
          bus.pass <= 1'b0;
          bus.busy <= 1'b1;
          bus.pi <= '0;
          drv_idx <= (NUM_PI+1)'(1);
        end
        DRIVE: if (drv_idx == (NUM_PI+1)'(TT_W)) begin
          state <= DRAIN;
          dcnt <= '0;
        end else begin
          bus.pi <= drv_idx[NUM_PI-1:0];
          drv_idx <= drv_idx + (NUM_PI+1)'(1);
        end
        DRAIN: if (dcnt == 3'(LATENCY)) begin
          state <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          bus.pass <= bus.captured_tt == exp_q;
        end else dcnt <= dcnt + 3'd1;
        DONE: state <= IDLE;
      endcase
      if (tap_v) begin
        bus.captured_tt[tap_idx] <= bus.po;
        if (bus.po != exp_q[tap_idx]) begin
          bus.mismatch_cnt <= bus.mismatch_cnt + (NUM_PI+1)'(1);
          if (bus.mismatch_cnt == '0) bus.first_bad <= tap_idx;
        end
      end
    end
endmodule
